// File: rtl/sap1_loader_if.sv
// sap1_loader_if: program-byte handshake plus the RAM, address-mux and CPU-clear
// controls driven by the SAP-1 loader.
interface sap1_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              start;
    logic              byte_valid;
    logic [DATA_W-1:0] byte_in;
    logic              byte_ready;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] prog_data;
    logic              WE_bar;
    logic              run_or_prog;
    logic              CPU_CLR_bar;
    logic              done;
    logic              error;
    modport master (
        output start, byte_valid, byte_in,
        input  byte_ready, address, prog_data, WE_bar, run_or_prog, CPU_CLR_bar, done, error
    );
    modport slave (
        input  start, byte_valid, byte_in,
        output byte_ready, address, prog_data, WE_bar, run_or_prog, CPU_CLR_bar, done, error
    );
endinterface

// File: rtl/sap1_loader.sv
// sap1_loader: writes N_WORDS program bytes into SAP-1 RAM, then hands the mux to MAR and
// releases the CPU. LOADER_CHECKSUM_EN adds a trailing checksum byte that must zero the sum.
module sap1_loader #(
    parameter int N_WORDS = 16,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8
) (
    input logic          CLK,
    input logic          CLR_bar,
    sap1_loader_if.slave bus
);
`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, WAIT_BYTE, WRITE, HOLD, WAIT_SUM, RUN, ERROR} state_t;
    localparam state_t LAST_NEXT = WAIT_SUM;
`else
    typedef enum logic [2:0] {IDLE, WAIT_BYTE, WRITE, HOLD, RUN} state_t;
    localparam state_t LAST_NEXT = RUN;
`endif
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_WORDS - 1);
    state_t            state, state_n;
    logic [ADDR_W-1:0] address_n;
    logic [DATA_W-1:0] data_n;
    logic              take;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum, total;
    assign bus.byte_ready = (state == WAIT_BYTE || state == WAIT_SUM) && !bus.start;
    assign total = sum + bus.byte_in;
`else
    assign bus.byte_ready = state == WAIT_BYTE && !bus.start;
`endif
    assign take = bus.byte_ready && bus.byte_valid;
    always_comb begin
        state_n   = state;
        address_n = bus.address;
        data_n    = bus.prog_data;
        if (bus.start) begin
            state_n   = WAIT_BYTE;
            address_n = '0;
        end else begin
            case (state)
                WAIT_BYTE: if (take) begin state_n = WRITE; data_n = bus.byte_in; end
                WRITE:     state_n = HOLD;
                HOLD: begin
                    state_n   = bus.address < LAST ? WAIT_BYTE : LAST_NEXT;
                    address_n = bus.address < LAST ? bus.address + 1'b1 : bus.address;
                end
`ifdef LOADER_CHECKSUM_EN
                WAIT_SUM:  if (take) state_n = total == '0 ? RUN : ERROR;
`endif
                default: ;
            endcase
        end
    end
    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge CLK) begin
        if (!CLR_bar) begin
            state           <= IDLE;
            bus.address     <= '0;
            bus.prog_data   <= '0;
            bus.WE_bar      <= 1'b1;
            bus.run_or_prog <= 1'b0;
            bus.CPU_CLR_bar <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            state           <= state_n;
            bus.address     <= address_n;
            bus.prog_data   <= data_n;
            bus.WE_bar      <= state_n != WRITE;
            bus.run_or_prog <= state_n == RUN;
            bus.CPU_CLR_bar <= state_n == RUN;
            bus.done        <= state_n == RUN;
        end
    end
`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge CLK) begin
        sum       <= (!CLR_bar || bus.start) ? '0 : (state == WAIT_BYTE && take) ? total : sum;
        bus.error <= CLR_bar && state_n == ERROR;
    end
`else
    assign bus.error = 1'b0;
`endif
endmodule

// File: tb/tb_sap1_loader.sv
// tb_sap1_loader: table of full loads checked by a write scoreboard, plus directed
// abort, mid-load reset and idle sequences.
module tb_sap1_loader;
    localparam int N = 16;
    typedef struct {
        logic [7:0] base;
        logic [7:0] inc;
        int         gap_max;
        logic [7:0] csum_off;
        logic [5:0] exp_fin;  // {done, run_or_prog, CPU_CLR_bar, WE_bar, byte_ready, error}
    } load_t;
    logic        clk = 1'b0;
    logic        clr_bar = 1'b0;
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [3:0]  exp_addr = '0;
    logic [11:0] sb[$];
    logic [11:0] e;
    int          wr_cyc[$];
    logic        prev_we = 1'b1;
    load_t       rows[$];
    sap1_loader_if bus ();
    sap1_loader dut (.CLK(clk), .CLR_bar(clr_bar), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    function automatic logic [5:0] st();
        return {bus.done, bus.run_or_prog, bus.CPU_CLR_bar, bus.WE_bar, bus.byte_ready, bus.error};
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // Every low WE_bar cycle must match the oldest accepted byte, with the CPU still held.
    always @(negedge clk) begin
        if (bus.WE_bar === 1'b0) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_write: addr=%h data=%h with no byte pending", bus.address, bus.prog_data);
            end else begin
                e = sb.pop_front();
                chk("write", 32'({bus.address, bus.prog_data, bus.done, bus.run_or_prog, bus.CPU_CLR_bar, prev_we}),
                    32'({e, 4'b0001}));
            end
            wr_cyc.push_back(cyc);
        end
        prev_we = bus.WE_bar;
    end
    task automatic send(input logic [7:0] d, input int gap, input bit wr);
        int t = 0;
        if (gap > 0) begin
            bus.byte_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        bus.byte_valid = 1'b1;
        bus.byte_in    = d;
        #1;
        while (!bus.byte_ready && t < 30) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!bus.byte_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL ready_timeout: byte %h not accepted, byte_ready=%b required 1", d, bus.byte_ready);
        end else if (wr) begin
            sb.push_back({exp_addr, d});
            exp_addr++;
        end
        @(negedge clk);
    endtask
    task automatic start_pulse();
        bus.start = 1'b1;
        #1;
        chk("ready_during_start", 32'(bus.byte_ready), 32'(0));
        @(negedge clk);
        bus.start = 1'b0;
        exp_addr  = '0;
        #1;
        chk("after_start", 32'({bus.address, st()}), 32'({4'd0, 6'b000110}));
    endtask
    task automatic do_load(input load_t r);
        logic [7:0] s = '0;
        logic [7:0] d;
        start_pulse();
        for (int i = 0; i < N; i++) begin
            d = r.base + r.inc * 8'(i);
            s += d;
            send(d, r.gap_max == 0 ? 0 : int'($urandom_range(0, r.gap_max)), 1'b1);
        end
`ifdef LOADER_CHECKSUM_EN
        send(8'd0 - s + r.csum_off, 0, 1'b0);
`else
        @(negedge clk);
        chk("hold", 32'(st()), 32'(6'b000100));
        @(negedge clk);
`endif
        chk("final", 32'({bus.address, st()}), 32'({4'(N - 1), r.exp_fin}));
        repeat (2) @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask
    initial begin
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in    = '0;
        rows.push_back('{8'h10, 8'h01, 0, 8'h00, 6'b111100});
        rows.push_back('{8'h40, 8'h03, 5, 8'h00, 6'b111100});
        rows.push_back('{8'hC0, 8'hFF, 2, 8'h00, 6'b111100});
`ifdef LOADER_CHECKSUM_EN
        rows.push_back('{8'h01, 8'h00, 0, 8'h00, 6'b111100});
        rows.push_back('{8'h01, 8'h00, 1, 8'h01, 6'b000101});
        rows.push_back('{8'h22, 8'h01, 0, 8'h00, 6'b111100});
`endif
        repeat (2) @(negedge clk);
        clr_bar = 1'b1;
        #1;
        chk("reset", 32'({bus.address, bus.prog_data, st()}), 32'({4'd0, 8'd0, 6'b000100}));
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'h5A;
        repeat (3) @(negedge clk);
        #1;
        chk("idle_ready", 32'(bus.byte_ready), 32'(0));
        bus.byte_valid = 1'b0;
        foreach (rows[k]) begin
            wr_cyc.delete();
            do_load(rows[k]);
            chk("write_count", 32'(wr_cyc.size()), 32'(N));
            if (rows[k].gap_max == 0)
                for (int i = 1; i < wr_cyc.size(); i++)
                    chk("spacing", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'(3));
        end
        // Abort after five bytes: the restart lands while the fifth strobe is low.
        start_pulse();
        for (int i = 0; i < 5; i++) send(8'h50 + 8'(i), 0, 1'b1);
        do_load('{8'hA0, 8'h01, 0, 8'h00, 6'b111100});
        // Reset during the write of address 7, then a clean reload from address 0.
        start_pulse();
        for (int i = 0; i < 8; i++) send(8'h60 + 8'(i), 0, 1'b1);
        clr_bar = 1'b0;
        @(negedge clk);
        chk("reset_mid_load", 32'({bus.address, st()}), 32'({4'd0, 6'b000100}));
        clr_bar = 1'b1;
        @(negedge clk);
        #1;
        chk("ready_after_reset", 32'(bus.byte_ready), 32'(0));
        bus.byte_valid = 1'b0;
        do_load('{8'h70, 8'h01, 1, 8'h00, 6'b111100});
        chk("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end
endmodule
